// File: rtl/parallel_serial_tx.sv
// Byte-to-serial transmitter: sends a sync comma burst after reset, then one byte per 8 bit-times,
// MSB first, with a comma in idle slots. Optional idle counter under `PS_TX_IDLE_COUNT_EN.
module parallel_serial_tx #(
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter int unsigned SYNC_COMMAS = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready,
    output logic       data_out,
`ifdef PS_TX_IDLE_COUNT_EN
    output logic [7:0] idle_cnt,
`endif
    output logic       tx_active
);

    typedef enum logic [0:0] {StSync, StActive} state_e;

    localparam logic [3:0] SyncLast = 4'(SYNC_COMMAS - 1);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] comma_cnt_q, comma_cnt_d;
    logic       load;
    logic       accept;

    assign load   = (bit_cnt_q == 3'd7);
    assign ready  = (state_q == StActive) && load;
    assign accept = ready && valid_in;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q     <= StSync;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd7;
            comma_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        shift_d     = {shift_q[6:0], 1'b0};
        if (load) begin
            // data_in is only selected on an accept edge, so X on it never reaches the shifter.
            shift_d = accept ? data_in : COMMA;
            if (state_q == StSync) begin
                comma_cnt_d = comma_cnt_q + 4'd1;
                if (comma_cnt_q == SyncLast) begin
                    state_d = StActive;
                end
            end
        end
    end

    assign data_out  = shift_q[7];
    assign tx_active = (state_q == StActive);

`ifdef PS_TX_IDLE_COUNT_EN
    logic [7:0] idle_cnt_q, idle_cnt_d;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= 8'h00;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (ready && !valid_in && (idle_cnt_q != 8'hFF)) begin
            idle_cnt_d = idle_cnt_q + 8'd1;
        end
    end

    assign idle_cnt = idle_cnt_q;
`endif

endmodule

// File: tb/tb_parallel_serial_tx.sv
// Directed bench for parallel_serial_tx: sync burst, data stream table, idle insertion,
// ignored off-slot pulses and mid-byte reset.
module tb_parallel_serial_tx;

    logic       clk_32f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready;
    logic       data_out;
    logic       tx_active;
`ifdef PS_TX_IDLE_COUNT_EN
    logic [7:0] idle_cnt;
`endif

    int n_checks;
    int n_pass;

    parallel_serial_tx dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready),
        .data_out (data_out),
`ifdef PS_TX_IDLE_COUNT_EN
        .idle_cnt (idle_cnt),
`endif
        .tx_active(tx_active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_32f);
        #1;
    endtask

    // Entered just after an edge leaving ready high; leaves at the next such point.
    task automatic send_slot(input logic v, input logic [7:0] d, input int pulse_at,
                             output logic [7:0] got);
        int rdy_mid;
        rdy_mid = 0;
        chk("ready_at_load", {31'd0, ready}, 32'd1);
        valid_in = v;
        data_in  = d;
        step();
        got[7] = data_out;
        for (int i = 1; i < 8; i++) begin
            if (pulse_at != 0 && i == pulse_at) begin
                valid_in = 1'b1;
                data_in  = 8'h11;
            end
            if (pulse_at != 0 && i == pulse_at + 1) begin
                valid_in = 1'b0;
                data_in  = 8'hxx;
            end
            step();
            got[7-i] = data_out;
            if (i < 7 && ready) rdy_mid++;
        end
        chk("ready_mid_slot", rdy_mid, 0);
    endtask

    // Runs edges 1..32 after reset release, checking the comma burst and first ready.
    task automatic sync_burst(input string tag);
        logic [7:0] b;
        int         early_rdy;
        early_rdy = 0;
        b = 8'h00;
        for (int e = 1; e <= 32; e++) begin
            step();
            b = {b[6:0], data_out};
            if (e % 8 == 0) chk({tag, "_sync_byte"}, {24'd0, b}, 32'hBC);
            if (e < 32 && ready) early_rdy++;
            if (e == 24) chk({tag, "_tx_active_e24"}, {31'd0, tx_active}, 32'd0);
        end
        chk({tag, "_no_early_ready"}, early_rdy, 0);
        chk({tag, "_ready_e32"}, {31'd0, ready}, 32'd1);
        chk({tag, "_tx_active_e32"}, {31'd0, tx_active}, 32'd1);
    endtask

    initial begin
        logic [7:0] got;
        n_checks = 0;
        n_pass   = 0;

        vecs[0]  = '{1'b1, 8'hAA, 8'hAA};
        vecs[1]  = '{1'b1, 8'hBB, 8'hBB};
        vecs[2]  = '{1'b1, 8'hCC, 8'hCC};
        vecs[3]  = '{1'b1, 8'hDD, 8'hDD};
        vecs[4]  = '{1'b1, 8'hEE, 8'hEE};
        vecs[5]  = '{1'b1, 8'hBC, 8'hBC};
        vecs[6]  = '{1'b1, 8'hFF, 8'hFF};
        vecs[7]  = '{1'b1, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, 8'h33, 8'hBC};
        vecs[9]  = '{1'b0, 8'h44, 8'hBC};
        vecs[10] = '{1'b1, 8'h5A, 8'h5A};

        // Reset state and sync burst with nothing offered.
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        #3;
        chk("rst_data_out", {31'd0, data_out}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_tx_active", {31'd0, tx_active}, 32'd0);
`ifdef PS_TX_IDLE_COUNT_EN
        chk("rst_idle_cnt", {24'd0, idle_cnt}, 32'd0);
`endif
        step();
        reset = 1'b1;
        sync_burst("t1");

        // Reset again, valid_in high from release: sync ignores it, AA follows with no gap.
        reset = 1'b0;
        #1;
        chk("t2_rst_data_out", {31'd0, data_out}, 32'd0);
        chk("t2_rst_ready", {31'd0, ready}, 32'd0);
        valid_in = 1'b1;
        data_in  = 8'hAA;
        reset    = 1'b1;
        sync_burst("t2");
        send_slot(1'b1, 8'hAA, 0, got);
        chk("t2_first_byte", {24'd0, got}, 32'hAA);
        send_slot(1'b1, 8'hAA, 0, got);
        chk("t2_second_byte", {24'd0, got}, 32'hAA);

        // Mixed stream plus two idle slots.
        for (int i = 0; i < 11; i++) begin
            send_slot(vecs[i].valid, vecs[i].data, 0, got);
            chk($sformatf("vec%0d_byte", i), {24'd0, got}, {24'd0, vecs[i].exp});
        end
`ifdef PS_TX_IDLE_COUNT_EN
        chk("idle_cnt_after_2", {24'd0, idle_cnt}, 32'd2);
`endif

        // One-cycle valid pulse away from ready must not be sent.
        send_slot(1'b0, 8'h00, 3, got);
        chk("pulse_slot_a", {24'd0, got}, 32'hBC);
        send_slot(1'b0, 8'h00, 0, got);
        chk("pulse_slot_b", {24'd0, got}, 32'hBC);
        chk("pulse_tx_active", {31'd0, tx_active}, 32'd1);
`ifdef PS_TX_IDLE_COUNT_EN
        chk("idle_cnt_after_4", {24'd0, idle_cnt}, 32'd4);
`endif

        // Reset after the third bit of FF: line drops at once, sync restarts.
        chk("t5_ready_at_load", {31'd0, ready}, 32'd1);
        valid_in = 1'b1;
        data_in  = 8'hFF;
        step();
        step();
        step();
        chk("t5_bit3_high", {31'd0, data_out}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_rst_data_out", {31'd0, data_out}, 32'd0);
        chk("t5_rst_tx_active", {31'd0, tx_active}, 32'd0);
`ifdef PS_TX_IDLE_COUNT_EN
        chk("t5_rst_idle_cnt", {24'd0, idle_cnt}, 32'd0);
`endif
        reset = 1'b1;
        sync_burst("t5");
        send_slot(1'b1, 8'hFF, 0, got);
        chk("t5_byte_after_sync", {24'd0, got}, 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
